// File: rtl/cp0_regfile_pkg.sv
// Shared CP0 constants: register numbers, ExcCode values, Status/Cause bit positions.
// No logic, so no latency.
// No flow control.
package cp0_regfile_pkg;

    // CP0 register numbers (MTC0/MFC0 rd field)
    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    // ExcCode values
    typedef enum logic [4:0] {
        EXC_INT  = 5'h00,
        EXC_ADEL = 5'h04,
        EXC_ADES = 5'h05,
        EXC_SYS  = 5'h08,
        EXC_BP   = 5'h09,
        EXC_RI   = 5'h0a,
        EXC_OV   = 5'h0c
    } exc_code_e;

    // Status bit positions
    localparam int STATUS_IE    = 0;
    localparam int STATUS_EXL   = 1;
    localparam int STATUS_IM_LO = 8;
    localparam int STATUS_IM_HI = 15;
    localparam int STATUS_BEV   = 22;

    // Cause bit positions
    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_EXC_HI = 6;
    localparam int CAUSE_IP_LO  = 8;
    localparam int CAUSE_IP_HI  = 15;
    localparam int CAUSE_TI     = 30;
    localparam int CAUSE_BD     = 31;

    // Address-error exceptions are the only ones that capture BadVAddr.
    function automatic logic is_addr_exc(input logic [4:0] code);
        return (code == EXC_ADEL) || (code == EXC_ADES);
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// CP0 timer: clock divider, Count, Compare and the sticky timer-interrupt flag TI.
// Loads take effect at the next edge; TI sets the edge after Count == Compare is seen.
// No backpressure: load strobes are single-cycle commits and are always accepted.
//
// Ports: clk, reset (sync, active-low); count_we / compare_we load wdata into
// Count / Compare; count, compare, ti are the registered timer state.
module cp0_timer
    import cp0_regfile_pkg::*;
#(
    parameter int COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    // A divide-by-one still needs a 1-bit phase register; it simply stays 0.
    localparam int             DIV_W    = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [31:0]      count_q, count_d;
    logic [31:0]      compare_q, compare_d;
    logic             ti_q, ti_d;

    always_comb begin
        div_d     = div_q;
        count_d   = count_q;
        compare_d = compare_q;
        ti_d      = ti_q;

        // A software load restarts the divider so the first increment after
        // a write is a full COUNT_DIV period away.
        if (count_we) begin
            count_d = wdata;
            div_d   = '0;
        end else if (div_q == DIV_LAST) begin
            div_d   = '0;
            count_d = count_q + 32'd1;
        end else begin
            div_d   = div_q + DIV_W'(1);
        end

        // Writing Compare is the acknowledge for the timer interrupt, so it
        // beats a simultaneous match.
        if (compare_we) begin
            compare_d = wdata;
            ti_d      = 1'b0;
        end else if (count_q == compare_q) begin
            ti_d      = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            div_q     <= '0;
            count_q   <= '0;
            compare_q <= '0;
            ti_q      <= 1'b0;
        end else begin
            div_q     <= div_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
        end
    end

    assign count   = count_q;
    assign compare = compare_q;
    assign ti      = ti_q;

endmodule

// File: rtl/cp0_regfile.sv
// CP0 register file: Status, Cause, EPC, Count, Compare, BadVAddr, exception/ERET entry and interrupt request.
// Writes land at the next edge; rdata/epc/status_exl/int_req are combinational from registers.
// No backpressure: ex > eret > mtc0_we in one cycle, a losing MTC0 is dropped.
//
// Ports: clk, reset (sync, active-low); raddr/rdata MFC0 read; mtc0_we/waddr/wdata
// MTC0 write; ex, ex_code, ex_bd, ex_pc, ex_badvaddr exception commit; eret ERET
// commit; hw_int level interrupts; int_req, epc, status_exl to the pipeline.
module cp0_regfile
    import cp0_regfile_pkg::*;
#(
    parameter int HW_INT_NUM = 6,
    parameter int COUNT_DIV  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4:0]            raddr,
    output logic [31:0]           rdata,
    input  logic                  mtc0_we,
    input  logic [4:0]            waddr,
    input  logic [31:0]           wdata,
    input  logic                  ex,
    input  logic [4:0]            ex_code,
    input  logic                  ex_bd,
    input  logic [31:0]           ex_pc,
    input  logic [31:0]           ex_badvaddr,
    input  logic                  eret,
    input  logic [HW_INT_NUM-1:0] hw_int,
    output logic                  int_req,
    output logic [31:0]           epc,
    output logic                  status_exl
);

    logic [7:0]            im_q, im_d;
    logic                  exl_q, exl_d;
    logic                  ie_q, ie_d;
    logic                  bd_q, bd_d;
    logic [4:0]            exccode_q, exccode_d;
    logic [1:0]            ip_sw_q, ip_sw_d;
    logic [HW_INT_NUM-1:0] hw_q, hw_d;
    logic [31:0]           epc_q, epc_d;
    logic [31:0]           badvaddr_q, badvaddr_d;

    logic                  sw_we;
    logic                  count_we;
    logic                  compare_we;
    logic [31:0]           count;
    logic [31:0]           compare;
    logic                  ti;
    logic [5:0]            hw_ext;
    logic [7:0]            ip;
    logic [31:0]           status_val;
    logic [31:0]           cause_val;

    // MTC0 only commits when neither an exception nor an ERET retires this cycle.
    assign sw_we      = mtc0_we & ~ex & ~eret;
    assign count_we   = sw_we & (waddr == CP0_COUNT);
    assign compare_we = sw_we & (waddr == CP0_COMPARE);

    cp0_timer #(
        .COUNT_DIV (COUNT_DIV)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .count_we   (count_we),
        .compare_we (compare_we),
        .wdata      (wdata),
        .count      (count),
        .compare    (compare),
        .ti         (ti)
    );

    // Unused interrupt lines zero-extend to 0. IP[7] is shared between the
    // sixth hardware line (when present) and the timer.
    assign hw_ext = 6'(hw_q);
    assign ip     = {hw_ext[5] | ti, hw_ext[4:0], ip_sw_q};

    always_comb begin
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        exccode_d  = exccode_q;
        ip_sw_d    = ip_sw_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;
        hw_d       = hw_int;

        if (ex) begin
            exccode_d = ex_code;
            exl_d     = 1'b1;
            // A nested exception must not clobber the return point of the
            // outer one.
            if (!exl_q) begin
                epc_d = ex_bd ? (ex_pc - 32'd4) : ex_pc;
                bd_d  = ex_bd;
            end
            if (is_addr_exc(ex_code)) begin
                badvaddr_d = ex_badvaddr;
            end
        end else if (eret) begin
            exl_d = 1'b0;
        end else if (mtc0_we) begin
            // Count and Compare writes are handled inside the timer.
            case (waddr)
                CP0_STATUS: begin
                    im_d  = wdata[STATUS_IM_HI:STATUS_IM_LO];
                    exl_d = wdata[STATUS_EXL];
                    ie_d  = wdata[STATUS_IE];
                end
                CP0_CAUSE:    ip_sw_d    = wdata[CAUSE_IP_LO+1:CAUSE_IP_LO];
                CP0_EPC:      epc_d      = wdata;
                CP0_BADVADDR: badvaddr_d = wdata;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            im_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            exccode_q  <= '0;
            ip_sw_q    <= '0;
            hw_q       <= '0;
            epc_q      <= '0;
            badvaddr_q <= '0;
        end else begin
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            exccode_q  <= exccode_d;
            ip_sw_q    <= ip_sw_d;
            hw_q       <= hw_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
        end
    end

    always_comb begin
        status_val                            = '0;
        status_val[STATUS_BEV]                = 1'b1;
        status_val[STATUS_IM_HI:STATUS_IM_LO] = im_q;
        status_val[STATUS_EXL]                = exl_q;
        status_val[STATUS_IE]                 = ie_q;

        cause_val                             = '0;
        cause_val[CAUSE_BD]                   = bd_q;
        cause_val[CAUSE_TI]                   = ti;
        cause_val[CAUSE_IP_HI:CAUSE_IP_LO]    = ip;
        cause_val[CAUSE_EXC_HI:CAUSE_EXC_LO]  = exccode_q;

        case (raddr)
            CP0_STATUS:   rdata = status_val;
            CP0_CAUSE:    rdata = cause_val;
            CP0_EPC:      rdata = epc_q;
            CP0_COUNT:    rdata = count;
            CP0_COMPARE:  rdata = compare;
            CP0_BADVADDR: rdata = badvaddr_q;
            default:      rdata = '0;
        endcase
    end

    assign int_req    = (|(ip & im_q)) & ie_q & ~exl_q;
    assign epc        = epc_q;
    assign status_exl = exl_q;

endmodule
